// File: rtl/ef_pkg.sv
// Shared types and constants for the extremum scheduler slice.
package ef_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    LATCH = 2'd3
  } ef_state_t;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  localparam logic [15:0] EF_MAX_POS = 16'h7FFF;
  localparam logic [15:0] EF_MAX_NEG = 16'h8000;

  localparam int TIMEOUT_MARGIN = 16;

endpackage

// File: rtl/extremum_scheduler_if.sv
// ADC stream input and finder-core handshake grouped for the scheduler.
// slave = scheduler side, master = stream source / finder core side.
interface extremum_scheduler_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  localparam int W = AXIS_TDATA_WIDTH / 2;

  logic                        S_AXIS_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
  logic                        S_AXIS_tready;

  logic                        CORE_start;
  logic [4:0]                  CORE_log_count;
  logic [2:0]                  CORE_shift;
  logic                        CORE_tvalid;
  logic [W-1:0]                CORE_tdata;
  logic                        CORE_done;
  logic [W-1:0]                CORE_lower;
  logic [W-1:0]                CORE_upper;

  modport slave (
    input  S_AXIS_tvalid, S_AXIS_tdata, CORE_done, CORE_lower, CORE_upper,
    output S_AXIS_tready, CORE_start, CORE_log_count, CORE_shift,
           CORE_tvalid, CORE_tdata
  );

  modport master (
    output S_AXIS_tvalid, S_AXIS_tdata, CORE_done, CORE_lower, CORE_upper,
    input  S_AXIS_tready, CORE_start, CORE_log_count, CORE_shift,
           CORE_tvalid, CORE_tdata
  );

endinterface

// File: rtl/ef_rr_select.sv
// Round-robin channel pick: first enabled channel after last_ch, and whether
// serving last_ch completes the pass given the channels already served.
module ef_rr_select
  import ef_pkg::*;
(
  input  logic [1:0] mask,
  input  logic       last_ch,
  input  logic [1:0] served,
  output logic       next_ch,
  output logic       last_in_pass
);

  logic [1:0] served_now;

  always_comb begin
    if (last_ch == CH_A) next_ch = mask[CH_B] ? CH_B : CH_A;
    else                 next_ch = mask[CH_A] ? CH_A : CH_B;
    served_now   = served | (2'b01 << last_ch);
    last_in_pass = ((served_now & mask) == mask);
  end

endmodule

// File: rtl/extremum_scheduler.sv
// Time-shares one extremum-finder core between ADC channels A/B in round-robin.
// Optional RUN watchdog: define EF_TIMEOUT_EN.
//   state | meaning
//   IDLE  | waiting for enable with a non-empty mask
//   START | CORE_start pulse, shadow settings stable
//   RUN   | forwarding selected channel to the core
//   LATCH | writing captured thresholds, choosing next window
module extremum_scheduler
  import ef_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            CFG_enable,
  input  logic                            CFG_single,
  input  logic [1:0]                      CFG_mask,
  input  logic [4:0]                      CFG_log_count,
  input  logic [2:0]                      CFG_shift,
  extremum_scheduler_if.slave             bus,
  output logic [AXIS_TDATA_WIDTH/2-1:0]   EF_lower_a,
  output logic [AXIS_TDATA_WIDTH/2-1:0]   EF_upper_a,
  output logic [AXIS_TDATA_WIDTH/2-1:0]   EF_lower_b,
  output logic [AXIS_TDATA_WIDTH/2-1:0]   EF_upper_b,
  output logic [1:0]                      EF_valid,
  output logic                            EF_busy,
  output logic                            EF_pass_done,
  output logic                            EF_timeout
);

  localparam int W = AXIS_TDATA_WIDTH / 2;
  localparam logic [W-1:0] LOWER_RST = W'(EF_MAX_POS);
  localparam logic [W-1:0] UPPER_RST = W'(EF_MAX_NEG);

  ef_state_t  state;
  logic       sel_ch;
  logic [1:0] served;
  logic       pass_hold;
  logic [4:0] shadow_log;
  logic [2:0] shadow_shift;
  logic       core_start;
  logic [W-1:0] lo_cap, hi_cap;
  logic       rr_next, rr_last;
  logic [W-1:0] sample_sel;

`ifdef EF_TIMEOUT_EN
  logic        timeout_q;
  logic [32:0] wd_cnt;
`endif

  ef_rr_select u_rr (
    .mask         (CFG_mask),
    .last_ch      (sel_ch),
    .served       (served),
    .next_ch      (rr_next),
    .last_in_pass (rr_last)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      sel_ch       <= CH_B;
      served       <= 2'b00;
      pass_hold    <= 1'b0;
      shadow_log   <= '0;
      shadow_shift <= '0;
      core_start   <= 1'b0;
      lo_cap       <= '0;
      hi_cap       <= '0;
      EF_lower_a   <= LOWER_RST;
      EF_upper_a   <= UPPER_RST;
      EF_lower_b   <= LOWER_RST;
      EF_upper_b   <= UPPER_RST;
      EF_valid     <= 2'b00;
      EF_pass_done <= 1'b0;
`ifdef EF_TIMEOUT_EN
      timeout_q    <= 1'b0;
      wd_cnt       <= '0;
`endif
    end else begin
      core_start   <= 1'b0;
      EF_pass_done <= 1'b0;
      // a finished single pass stays parked until enable is seen low
      if (!CFG_enable) pass_hold <= 1'b0;
      case (state)
        IDLE: begin
          served <= 2'b00;
          if (CFG_enable && (CFG_mask != 2'b00) && !pass_hold) begin
            sel_ch       <= rr_next;
            shadow_log   <= CFG_log_count;
            shadow_shift <= CFG_shift;
            core_start   <= 1'b1;
            state        <= START;
          end
        end
        START: begin
`ifdef EF_TIMEOUT_EN
          wd_cnt <= (33'd1 << shadow_log) + 33'(TIMEOUT_MARGIN - 1);
`endif
          state <= RUN;
        end
        RUN: begin
          if (bus.CORE_done) begin
            lo_cap       <= bus.CORE_lower;
            hi_cap       <= bus.CORE_upper;
            // decided here so the pulse sits in the LATCH cycle
            EF_pass_done <= CFG_single && rr_last;
            state        <= LATCH;
          end
`ifdef EF_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            timeout_q <= 1'b1;
            state     <= IDLE;
          end else begin
            wd_cnt <= wd_cnt - 33'd1;
          end
`endif
        end
        LATCH: begin
          if (sel_ch == CH_A) begin
            EF_lower_a <= lo_cap;
            EF_upper_a <= hi_cap;
          end else begin
            EF_lower_b <= lo_cap;
            EF_upper_b <= hi_cap;
          end
          EF_valid[sel_ch] <= 1'b1;
          if (EF_pass_done) begin
            pass_hold <= 1'b1;
            state     <= IDLE;
          end else if (!CFG_enable || (CFG_mask == 2'b00)) begin
            state <= IDLE;
          end else begin
            served       <= rr_last ? 2'b00 : (served | (2'b01 << sel_ch));
            sel_ch       <= rr_next;
            shadow_log   <= CFG_log_count;
            shadow_shift <= CFG_shift;
            core_start   <= 1'b1;
            state        <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sample_sel = (sel_ch == CH_B) ? bus.S_AXIS_tdata[AXIS_TDATA_WIDTH-1:W]
                                       : bus.S_AXIS_tdata[W-1:0];

  assign bus.S_AXIS_tready  = 1'b1;
  assign bus.CORE_start     = core_start;
  assign bus.CORE_log_count = shadow_log;
  assign bus.CORE_shift     = shadow_shift;
  assign bus.CORE_tvalid    = (state == RUN) & bus.S_AXIS_tvalid;
  assign bus.CORE_tdata     = (state == RUN) ? sample_sel : '0;
  assign EF_busy            = (state != IDLE);

`ifdef EF_TIMEOUT_EN
  assign EF_timeout = timeout_q;
`else
  assign EF_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_extremum_scheduler.sv
// Self-checking bench for extremum_scheduler: table of windows, corner
// sequences, and randomized continuous operation against a reference model.
module tb_extremum_scheduler;
  import ef_pkg::*;

  localparam int DW = 32;
  localparam int W  = 16;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic CFG_enable = 1'b0, CFG_single = 1'b0;
  logic [1:0] CFG_mask = 2'b00;
  logic [4:0] CFG_log_count = 5'd3;
  logic [2:0] CFG_shift = 3'd0;
  logic [W-1:0] EF_lower_a, EF_upper_a, EF_lower_b, EF_upper_b;
  logic [1:0] EF_valid;
  logic EF_busy, EF_pass_done, EF_timeout;

  extremum_scheduler_if #(.AXIS_TDATA_WIDTH(DW)) bus ();

  extremum_scheduler #(.AXIS_TDATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset),
    .CFG_enable(CFG_enable), .CFG_single(CFG_single), .CFG_mask(CFG_mask),
    .CFG_log_count(CFG_log_count), .CFG_shift(CFG_shift),
    .bus(bus),
    .EF_lower_a(EF_lower_a), .EF_upper_a(EF_upper_a),
    .EF_lower_b(EF_lower_b), .EF_upper_b(EF_upper_b),
    .EF_valid(EF_valid), .EF_busy(EF_busy),
    .EF_pass_done(EF_pass_done), .EF_timeout(EF_timeout)
  );

  always #5 aclk = ~aclk;

  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 0, core_ok = 1, b2b_chk = 0, win_fixed = 0;
  int done_delay = 9;
  int starts = 0, consumed = 0, dones = 0, last_done_cyc = 0;
  int run_cnt = 0, latch_cd = 0, pd_expect_cyc = -1;
  int obs_ch = -1, done_obs_ch = -1;
  bit in_run = 0;
  logic mdl_ch = 1'b0, mdl_last = 1'b1;
  logic [4:0] mdl_log = '0;
  logic [2:0] mdl_shift = '0;
  logic [W-1:0] mdl_lo [2];
  logic [W-1:0] mdl_hi [2];
  logic [1:0] mdl_valid = 2'b00, mdl_served = 2'b00;
  logic [W-1:0] win_lo = '0, win_hi = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic nxt(input logic last, input logic [1:0] m);
    logic other;
    other = ~last;
    return m[other] ? other : last;
  endfunction

  task automatic check_ef();
    chk("ef_lower_a", EF_lower_a, mdl_lo[0]);
    chk("ef_upper_a", EF_upper_a, mdl_hi[0]);
    chk("ef_lower_b", EF_lower_b, mdl_lo[1]);
    chk("ef_upper_b", EF_upper_b, mdl_hi[1]);
    chk("ef_valid",   EF_valid,   mdl_valid);
  endtask

  // stream source: distinct halves so the served channel is identifiable
  always @(negedge aclk) begin
    logic [W-1:0] a;
    #2;
    a = W'($urandom);
    bus.S_AXIS_tvalid = 1'($urandom);
    bus.S_AXIS_tdata  = {a ^ 16'hA5C3, a};
  end

  // monitor + finder-core model
  always @(negedge aclk) begin
    logic [W-1:0] lo, hi;
    cyc++;
    if (mon_en) begin
      if (in_run) begin
        chk("run_tvalid", bus.CORE_tvalid, bus.S_AXIS_tvalid);
        chk("run_tdata", bus.CORE_tdata,
            mdl_ch ? bus.S_AXIS_tdata[31:16] : bus.S_AXIS_tdata[15:0]);
        chk("run_log_count", bus.CORE_log_count, mdl_log);
        chk("run_shift", bus.CORE_shift, mdl_shift);
        if (obs_ch < 0) begin
          if (bus.CORE_tdata == bus.S_AXIS_tdata[15:0]) obs_ch = 0;
          else if (bus.CORE_tdata == bus.S_AXIS_tdata[31:16]) obs_ch = 1;
          else obs_ch = 2;
        end
      end else begin
        chk("idle_tvalid", bus.CORE_tvalid, 0);
        chk("idle_tdata", bus.CORE_tdata, 0);
      end
      chk("pass_done", EF_pass_done, (cyc == pd_expect_cyc));
      if (latch_cd > 0) begin
        latch_cd--;
        if (latch_cd == 0) check_ef();
      end
      bus.CORE_done  = 1'b0;
      bus.CORE_lower = W'($urandom);
      bus.CORE_upper = W'($urandom);
      if (in_run) begin
        run_cnt++;
        if (core_ok && run_cnt == done_delay) begin
          lo = win_fixed ? win_lo : W'($urandom);
          hi = win_fixed ? win_hi : W'($urandom);
          bus.CORE_done  = 1'b1;
          bus.CORE_lower = lo;
          bus.CORE_upper = hi;
          mdl_lo[mdl_ch] = lo;
          mdl_hi[mdl_ch] = hi;
          mdl_valid[mdl_ch] = 1'b1;
          mdl_served[mdl_ch] = 1'b1;
          if ((mdl_served & CFG_mask) == CFG_mask) begin
            if (CFG_single) pd_expect_cyc = cyc + 1;
            mdl_served = 2'b00;
          end
          done_obs_ch = obs_ch;
          in_run = 0;
          latch_cd = 2;
          dones++;
          last_done_cyc = cyc;
        end
      end
      if (bus.CORE_start) begin
        if (b2b_chk && dones > 0) chk("dead_time", cyc - last_done_cyc, 2);
        starts++;
        mdl_ch = nxt(mdl_last, CFG_mask);
        mdl_last = mdl_ch;
        mdl_log = CFG_log_count;
        mdl_shift = CFG_shift;
        in_run = 1;
        run_cnt = 0;
        obs_ch = -1;
      end
    end else begin
      bus.CORE_done  = 1'b0;
      bus.CORE_lower = '0;
      bus.CORE_upper = '0;
    end
  end

  task automatic sync();
    @(negedge aclk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lower_a"}, EF_lower_a, 16'h7FFF);
    chk({tag, "_upper_a"}, EF_upper_a, 16'h8000);
    chk({tag, "_lower_b"}, EF_lower_b, 16'h7FFF);
    chk({tag, "_upper_b"}, EF_upper_b, 16'h8000);
    chk({tag, "_valid"}, EF_valid, 0);
    chk({tag, "_busy"}, EF_busy, 0);
    chk({tag, "_pass_done"}, EF_pass_done, 0);
    chk({tag, "_timeout"}, EF_timeout, 0);
    chk({tag, "_core_start"}, bus.CORE_start, 0);
    chk({tag, "_core_tvalid"}, bus.CORE_tvalid, 0);
    chk({tag, "_core_tdata"}, bus.CORE_tdata, 0);
    chk({tag, "_core_log"}, bus.CORE_log_count, 0);
    chk({tag, "_core_shift"}, bus.CORE_shift, 0);
    chk({tag, "_tready"}, bus.S_AXIS_tready, 1);
  endtask

  task automatic do_reset();
    mon_en = 0;
    CFG_enable = 1'b0;
    CFG_single = 1'b0;
    areset = 1'b1;
    sync();
    sync();
    chk_reset_vals("rst");
    areset = 1'b0;
    mdl_last = 1'b1;
    mdl_valid = 2'b00;
    mdl_served = 2'b00;
    mdl_lo[0] = 16'h7FFF; mdl_lo[1] = 16'h7FFF;
    mdl_hi[0] = 16'h8000; mdl_hi[1] = 16'h8000;
    in_run = 0; latch_cd = 0; pd_expect_cyc = -1;
    starts = 0; consumed = 0; dones = 0;
    mon_en = 1;
  endtask

  task automatic wait_start(input int limit);
    int n;
    n = 0;
    while (starts <= consumed && n < limit) begin sync(); n++; end
    checks++;
    if (starts <= consumed) begin
      errors++;
      $display("FAIL wait_start: no CORE_start within %0d cycles", limit);
    end
    consumed++;
  endtask

  task automatic wait_done(input int limit);
    int tgt, n;
    tgt = dones + 1;
    n = 0;
    while (dones < tgt && n < limit) begin sync(); n++; end
    checks++;
    if (dones < tgt) begin
      errors++;
      $display("FAIL wait_done: no CORE_done within %0d cycles", limit);
    end
  endtask

  task automatic stop_idle();
    int n;
    CFG_enable = 1'b0;
    n = 0;
    while (EF_busy && n < 200) begin sync(); n++; end
    chk("stop_idle_busy", EF_busy, 0);
    sync();
    mdl_served = 2'b00;
    consumed = starts;
  endtask

  typedef struct {
    bit         rst;
    logic [1:0] mask;
    logic [15:0] lo, hi;
    int         ch;
    logic [1:0] valid;
    bit         last;
  } row_t;

  row_t tbl [6];

  initial begin
    int n;
    tbl[0] = '{1'b1, 2'b11, 16'h1234, 16'h5678, 0, 2'b01, 1'b0};
    tbl[1] = '{1'b0, 2'b11, 16'hF000, 16'h0FFF, 1, 2'b11, 1'b0};
    tbl[2] = '{1'b0, 2'b11, 16'h8001, 16'h7FFE, 0, 2'b11, 1'b0};
    tbl[3] = '{1'b0, 2'b11, 16'h0000, 16'h0001, 1, 2'b11, 1'b1};
    tbl[4] = '{1'b1, 2'b10, 16'hFF9C, 16'h00C8, 1, 2'b10, 1'b0};
    tbl[5] = '{1'b0, 2'b10, 16'hFFFF, 16'h0000, 1, 2'b10, 1'b1};

    // table-driven windows; last row of a group drops enable mid-RUN
    b2b_chk = 1;
    done_delay = 9;
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].rst) begin
        do_reset();
        CFG_mask = tbl[r].mask;
        CFG_log_count = 5'd3;
        CFG_enable = 1'b1;
      end
      wait_start(50);
      win_lo = tbl[r].lo;
      win_hi = tbl[r].hi;
      win_fixed = 1;
      if (tbl[r].last) CFG_enable = 1'b0;
      wait_done(50);
      sync();
      sync();
      chk("tbl_channel", done_obs_ch, tbl[r].ch);
      chk("tbl_valid", EF_valid, tbl[r].valid);
      chk("tbl_lower", (tbl[r].ch == 1) ? EF_lower_b : EF_lower_a, tbl[r].lo);
      chk("tbl_upper", (tbl[r].ch == 1) ? EF_upper_b : EF_upper_a, tbl[r].hi);
      if (tbl[r].last) begin
        chk("tbl_idle_after_drop", EF_busy, 0);
      end
    end
    chk("tbl_a_untouched_lo", EF_lower_a, 16'h7FFF);
    chk("tbl_a_untouched_hi", EF_upper_a, 16'h8000);
    win_fixed = 0;
    b2b_chk = 0;

    // single pass: two windows, one pulse, then parked while enable stays high
    do_reset();
    CFG_mask = 2'b11;
    CFG_single = 1'b1;
    CFG_enable = 1'b1;
    n = 0;
    while (!EF_pass_done && n < 200) begin sync(); n++; end
    chk("single_pulse_seen", EF_pass_done, 1);
    chk("single_busy_in_pulse", EF_busy, 1);
    chk("single_windows", starts, 2);
    sync();
    chk("single_busy_after", EF_busy, 0);
    repeat (40) sync();
    chk("single_no_restart", starts, 2);
    CFG_enable = 1'b0;
    sync();
    sync();
    mdl_served = 2'b00;
    consumed = starts;
    CFG_enable = 1'b1;
    wait_start(20);
    chk("single_rearm", starts, 3);
    stop_idle();
    CFG_single = 1'b0;

    // log_count change mid-RUN only affects the following window
    CFG_mask = 2'b01;
    CFG_log_count = 5'd3;
    CFG_enable = 1'b1;
    wait_start(20);
    repeat (3) sync();
    CFG_log_count = 5'd6;
    chk("log_held_in_run", bus.CORE_log_count, 3);
    wait_start(50);
    chk("log_next_window", bus.CORE_log_count, 6);
    stop_idle();

    // asynchronous reset in the middle of a window
    CFG_mask = 2'b11;
    CFG_log_count = 5'd3;
    CFG_enable = 1'b1;
    wait_start(20);
    repeat (3) sync();
    chk("pre_reset_busy", EF_busy, 1);
    mon_en = 0;
    #1 areset = 1'b1;
    #1 chk_reset_vals("async_rst");
    do_reset();

    // randomized continuous operation
    b2b_chk = 1;
    CFG_mask = 2'($urandom_range(1, 3));
    CFG_log_count = 5'($urandom_range(0, 31));
    CFG_shift = 3'($urandom);
    done_delay = $urandom_range(1, 20);
    CFG_enable = 1'b1;
    for (int w = 0; w < 40; w++) begin
      wait_done(60);
      if ($urandom_range(0, 2) == 0) CFG_mask = 2'($urandom_range(1, 3));
      CFG_log_count = 5'($urandom_range(0, 31));
      CFG_shift = 3'($urandom);
      done_delay = $urandom_range(1, 20);
    end
    b2b_chk = 0;
    stop_idle();
    sync();
    sync();
    check_ef();
    chk("final_timeout", EF_timeout, 0);

`ifdef EF_TIMEOUT_EN
    // watchdog: core never answers, log_count=2 -> 20 RUN cycles
    do_reset();
    mon_en = 0;
    core_ok = 0;
    CFG_mask = 2'b01;
    CFG_log_count = 5'd2;
    CFG_enable = 1'b1;
    n = 0;
    while (!EF_busy && n < 20) begin sync(); n++; end
    CFG_enable = 1'b0;
    n = 0;
    while (EF_busy && n < 100) begin sync(); n++; end
    chk("wd_run_cycles", n - 1, 20);
    chk("wd_timeout_set", EF_timeout, 1);
    chk("wd_lower_a", EF_lower_a, 16'h7FFF);
    chk("wd_upper_a", EF_upper_a, 16'h8000);
    chk("wd_valid", EF_valid, 0);
    core_ok = 1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
